// File: rtl/dfc_pkg.sv
// Shared types for the dual-channel frequency counter: FSM states and
// readout byte-select encodings.
package dfc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam logic [1:0] SEL_A_LO = 2'b00;
    localparam logic [1:0] SEL_A_HI = 2'b01;
    localparam logic [1:0] SEL_B_LO = 2'b10;
    localparam logic [1:0] SEL_B_HI = 2'b11;

endpackage

// File: rtl/dfc_edge_sync.sv
// Two-flop synchronizer plus history flop for an asynchronous oscillator input;
// emits a one-cycle pulse for each rising edge seen in the clk domain.
module dfc_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic osc_i,
    output logic pulse_o
);

    logic sync1_q;
    logic sync2_q;
    logic hist_q;

    // NOTE: non-blocking assignments make the three flops a true shift chain;
    // blocking ones would collapse it into a single stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            sync1_q <= osc_i;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign pulse_o = sync2_q & ~hist_q;

endmodule

// File: rtl/dual_freq_counter.sv
// Dual-channel gated frequency counter. Define DFC_CONTINUOUS_EN for
// back-to-back windows; the default build measures one window per ena assertion.
module dual_freq_counter
    import dfc_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int GATE_LOG2 = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       osc_a,
    input  logic       osc_b,
    input  logic [1:0] byte_sel,
    output logic [7:0] dout,
    output logic       valid,
    output logic       ovf_a,
    output logic       ovf_b
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e                 state_q;
    logic [GATE_LOG2-1:0]   gate_q;
    logic [CNT_W-1:0]       cnt_a_q, cnt_b_q;
    logic                   sat_a_q, sat_b_q;
    logic [CNT_W-1:0]       res_a_q, res_b_q;
    logic                   ovf_a_q, ovf_b_q;
    logic                   valid_q;

    logic                   pulse_a, pulse_b;
    logic [CNT_W-1:0]       cnt_a_d, cnt_b_d;
    logic                   sat_a_d, sat_b_d;
    logic                   term_d;

    dfc_edge_sync u_sync_a (.clk(clk), .rst_n(rst_n), .osc_i(osc_a), .pulse_o(pulse_a));
    dfc_edge_sync u_sync_b (.clk(clk), .rst_n(rst_n), .osc_i(osc_b), .pulse_o(pulse_b));

    // Saturating count including this cycle's pulse; an edge arriving at full
    // scale is recorded as overflow instead of wrapping.
    assign cnt_a_d = (pulse_a && cnt_a_q != CNT_MAX) ? cnt_a_q + CNT_W'(1) : cnt_a_q;
    assign cnt_b_d = (pulse_b && cnt_b_q != CNT_MAX) ? cnt_b_q + CNT_W'(1) : cnt_b_q;
    assign sat_a_d = sat_a_q | (pulse_a & (cnt_a_q == CNT_MAX));
    assign sat_b_d = sat_b_q | (pulse_b & (cnt_b_q == CNT_MAX));
    assign term_d  = (gate_q == '1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gate_q  <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            sat_a_q <= 1'b0;
            sat_b_q <= 1'b0;
            res_a_q <= '0;
            res_b_q <= '0;
            ovf_a_q <= 1'b0;
            ovf_b_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    gate_q  <= '0;
                    cnt_a_q <= '0;
                    cnt_b_q <= '0;
                    sat_a_q <= 1'b0;
                    sat_b_q <= 1'b0;
                    if (ena) state_q <= ST_MEASURE;
                end
                ST_MEASURE: begin
                    if (!ena || term_d) begin
                        gate_q  <= '0;
                        cnt_a_q <= '0;
                        cnt_b_q <= '0;
                        sat_a_q <= 1'b0;
                        sat_b_q <= 1'b0;
                    end else begin
                        gate_q  <= gate_q + GATE_LOG2'(1);
                        cnt_a_q <= cnt_a_d;
                        cnt_b_q <= cnt_b_d;
                        sat_a_q <= sat_a_d;
                        sat_b_q <= sat_b_d;
                    end
                    if (!ena) begin
                        state_q <= ST_IDLE;
                    end else if (term_d) begin
                        res_a_q <= cnt_a_d;
                        res_b_q <= cnt_b_d;
                        ovf_a_q <= sat_a_d;
                        ovf_b_q <= sat_b_d;
                        valid_q <= 1'b1;
`ifdef DFC_CONTINUOUS_EN
                        state_q <= ST_MEASURE;
`else
                        state_q <= ST_DONE;
`endif
                    end
                end
                ST_DONE: begin
                    if (!ena) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    logic [15:0] res_a_ext, res_b_ext;
    assign res_a_ext = 16'(res_a_q);
    assign res_b_ext = 16'(res_b_q);

    // NOTE: assigning dout before the case keeps this purely combinational
    // even if an encoding is ever left out.
    always_comb begin
        dout = 8'h00;
        case (byte_sel)
            SEL_A_LO: dout = res_a_ext[7:0];
            SEL_A_HI: dout = res_a_ext[15:8];
            SEL_B_LO: dout = res_b_ext[7:0];
            SEL_B_HI: dout = res_b_ext[15:8];
            default:  dout = 8'h00;
        endcase
    end

    assign valid = valid_q;
    assign ovf_a = ovf_a_q;
    assign ovf_b = ovf_b_q;

endmodule
